// File: rtl/dmem_multicore_arb_if.sv
// dmem_multicore_arb_if: per-core req/ack data-memory bus, flattened over NCORES ports.
interface dmem_multicore_arb_if #(
    parameter int NCORES = 2,
    parameter int TAM    = 16
);
    logic [NCORES*TAM-1:0] dataIN;
    logic [NCORES*TAM-1:0] dataADDR;
    logic [NCORES*2-1:0]   dataCTRL;
    logic [NCORES-1:0]     dataREQ;
    logic [NCORES*TAM-1:0] dataOUT;
    logic [NCORES-1:0]     dataACK;
    logic [NCORES-1:0]     dataERR;

    modport master (
        output dataIN, dataADDR, dataCTRL, dataREQ,
        input  dataOUT, dataACK, dataERR
    );

    modport slave (
        input  dataIN, dataADDR, dataCTRL, dataREQ,
        output dataOUT, dataACK, dataERR
    );
endinterface

// File: rtl/dmem_multicore_arb.sv
// dmem_multicore_arb: private bank per core plus one round-robin arbitrated shared bank.
// Optional DMEM_ATOMIC_SWAP_EN enables CTRL=11 swap; otherwise swap flags dataERR.
module dmem_multicore_arb #(
    parameter int NCORES  = 2,
    parameter int TAM     = 16,
    parameter int PRIV_AW = 8,
    parameter int SHR_AW  = 8
) (
    input logic clk,
    input logic rst,
    dmem_multicore_arb_if.slave bus
);
`ifdef DMEM_ATOMIC_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif
    localparam int PW = NCORES > 1 ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {IDLE, PWAIT, ACK} state_t;

    logic [NCORES-1:0][TAM-1:0] din_w, addr_w, din_q, out_q;
    logic [NCORES-1:0][1:0] ctrl_w, ctrl_q;
    logic [NCORES-1:0][SHR_AW-1:0] addr_q;
    logic [NCORES-1:0] cap, priv_go, ack, err;
    state_t state_q [NCORES];
    state_t state_d [NCORES];
    logic [PW-1:0] ptr_q, gnt_idx, idx;
    logic gnt_valid;
    logic [TAM-1:0] priv_mem [NCORES][2**PRIV_AW];
    logic [TAM-1:0] shr_mem [2**SHR_AW];
    logic unused_addr;

    assign din_w       = bus.dataIN;
    assign addr_w      = bus.dataADDR;
    assign ctrl_w      = bus.dataCTRL;
    assign unused_addr = ^addr_w;
    assign bus.dataOUT = out_q;
    assign bus.dataACK = ack;
    assign bus.dataERR = err;

    function automatic logic is_wr(input logic [1:0] c);
        return c == 2'b10 || (SWAP && c == 2'b11);
    endfunction

    function automatic logic is_rd(input logic [1:0] c);
        return c == 2'b01 || (SWAP && c == 2'b11);
    endfunction

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            cap[i]     = state_q[i] == IDLE && bus.dataREQ[i] && ctrl_w[i] != 2'b00;
            priv_go[i] = cap[i] && !addr_w[i][TAM-1];
        end
    end

    // first PWAIT core at or after the pointer, wrapping
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = PW'((int'(ptr_q) + k) % NCORES);
            if (!gnt_valid && state_q[idx] == PWAIT) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCORES; i++)
            state_d[i] = state_q[i] == IDLE  ? (cap[i] ? (addr_w[i][TAM-1] ? PWAIT : ACK) : IDLE) :
                         state_q[i] == PWAIT ? (gnt_valid && gnt_idx == PW'(i) ? ACK : PWAIT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '{default: IDLE};
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= gnt_valid ? (gnt_idx == PW'(NCORES-1) ? '0 : gnt_idx + 1'b1) : ptr_q;
        end
    end

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            ack[i] = state_q[i] == ACK;
            err[i] = ack[i] && !SWAP && ctrl_q[i] == 2'b11;
        end
    end

    // private ops execute on live inputs at capture; shared ops use the captured copy at grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= '0;
            ctrl_q <= '0;
            out_q  <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (cap[i]) begin
                    addr_q[i] <= addr_w[i][SHR_AW-1:0];
                    din_q[i]  <= din_w[i];
                    ctrl_q[i] <= ctrl_w[i];
                end
                if (priv_go[i] && is_rd(ctrl_w[i]))
                    out_q[i] <= priv_mem[i][addr_w[i][PRIV_AW-1:0]];
                else if (gnt_valid && gnt_idx == PW'(i) && is_rd(ctrl_q[i]))
                    out_q[i] <= shr_mem[addr_q[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORES; i++)
            if (priv_go[i] && is_wr(ctrl_w[i]))
                priv_mem[i][addr_w[i][PRIV_AW-1:0]] <= din_w[i];
        if (gnt_valid && is_wr(ctrl_q[gnt_idx]))
            shr_mem[addr_q[gnt_idx]] <= din_q[gnt_idx];
    end
endmodule

// File: tb/tb_dmem_multicore_arb.sv
// tb_dmem_multicore_arb: directed vector table plus contention, ordering and reset sequences.
module tb_dmem_multicore_arb;
    localparam int NC = 2;
    localparam int W  = 16;
`ifdef DMEM_ATOMIC_SWAP_EN
    localparam bit SW = 1'b1;
`else
    localparam bit SW = 1'b0;
`endif
    localparam logic [1:0] RD = 2'b01, WR = 2'b10, SWP = 2'b11;

    typedef struct {
        int          core;
        logic [1:0]  ctrl;
        logic [15:0] addr;
        logic [15:0] din;
        int          lat;
        logic [15:0] out;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int passed = 0;
    vec_t vt [15];

    dmem_multicore_arb_if #(.NCORES(NC), .TAM(W)) bus ();

    dmem_multicore_arb #(.NCORES(NC), .TAM(W), .PRIV_AW(8), .SHR_AW(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] outw(input int c);
        return bus.dataOUT[c*W +: W];
    endfunction

    task automatic drive(input int c, input logic [1:0] ctrl, input logic [15:0] addr, input logic [15:0] din);
        bus.dataREQ[c]            = 1'b1;
        bus.dataCTRL[c*2 +: 2]    = ctrl;
        bus.dataADDR[c*W +: W]    = addr;
        bus.dataIN[c*W +: W]      = din;
    endtask

    // latency counts clock edges from the capture edge to the ACK cycle; 0 means no ACK seen
    task automatic pair(input bit en0, input bit en1,
                        input logic [1:0] c0, input logic [1:0] c1,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        output int l0, output int l1,
                        output logic [15:0] o0, output logic [15:0] o1,
                        output logic e0, output logic e1);
        @(negedge clk);
        if (en0) drive(0, c0, a0, d0);
        if (en1) drive(1, c1, a1, d1);
        l0 = 0; l1 = 0; o0 = '0; o1 = '0; e0 = 1'b0; e1 = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            bus.dataREQ = '0;
            if (en0 && l0 == 0 && bus.dataACK[0]) begin l0 = n; o0 = outw(0); e0 = bus.dataERR[0]; end
            if (en1 && l1 == 0 && bus.dataACK[1]) begin l1 = n; o1 = outw(1); e1 = bus.dataERR[1]; end
            if ((!en0 || l0 != 0) && (!en1 || l1 != 0)) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.dataREQ = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int l0, l1;
        logic [15:0] o0, o1;
        logic e0, e1;
        logic [1:0] acks;

        vt[0]  = '{0, WR,  16'h00A5, 16'hBEEF, 1, 16'h0000, 1'b0};
        vt[1]  = '{0, RD,  16'h00A5, 16'h0000, 1, 16'hBEEF, 1'b0};
        vt[2]  = '{1, WR,  16'h00A5, 16'h1111, 1, 16'h0000, 1'b0};
        vt[3]  = '{1, RD,  16'h00A5, 16'h0000, 1, 16'h1111, 1'b0};
        vt[4]  = '{0, RD,  16'h00A5, 16'h0000, 1, 16'hBEEF, 1'b0};
        vt[5]  = '{1, WR,  16'h8010, 16'h1234, 2, 16'h1111, 1'b0};
        vt[6]  = '{0, RD,  16'h8010, 16'h0000, 2, 16'h1234, 1'b0};
        vt[7]  = '{0, RD,  16'h7FA5, 16'h0000, 1, 16'hBEEF, 1'b0};
        vt[8]  = '{1, RD,  16'hFF10, 16'h0000, 2, 16'h1234, 1'b0};
        vt[9]  = '{0, WR,  16'h8020, 16'h0F0F, 2, 16'hBEEF, 1'b0};
        vt[10] = '{0, SWP, 16'h8020, 16'hF0F0, 2, SW ? 16'h0F0F : 16'hBEEF, !SW};
        vt[11] = '{1, RD,  16'h8020, 16'h0000, 2, SW ? 16'hF0F0 : 16'h0F0F, 1'b0};
        vt[12] = '{1, WR,  16'h0003, 16'hAAAA, 1, SW ? 16'hF0F0 : 16'h0F0F, 1'b0};
        vt[13] = '{1, SWP, 16'h0003, 16'h5555, 1, SW ? 16'hAAAA : 16'h0F0F, !SW};
        vt[14] = '{1, RD,  16'h0003, 16'h0000, 1, SW ? 16'h5555 : 16'hAAAA, 1'b0};

        rst = 1'b1;
        bus.dataREQ = '0; bus.dataCTRL = '0; bus.dataADDR = '0; bus.dataIN = '0;
        repeat (2) @(negedge clk);
        chk("reset ack", 32'(bus.dataACK), 32'd0);
        chk("reset err", 32'(bus.dataERR), 32'd0);
        chk("reset out", 32'(bus.dataOUT), 32'd0);
        rst = 1'b0;

        @(negedge clk);
        bus.dataREQ = 2'b11;
        acks = '0;
        repeat (3) begin @(negedge clk); acks |= bus.dataACK; end
        bus.dataREQ = '0;
        chk("ctrl00 ignored", 32'(acks), 32'd0);

        foreach (vt[i]) begin
            pair(vt[i].core == 0, vt[i].core == 1, vt[i].ctrl, vt[i].ctrl, vt[i].addr, vt[i].addr,
                 vt[i].din, vt[i].din, l0, l1, o0, o1, e0, e1);
            chk($sformatf("v%0d lat", i), 32'(vt[i].core ? l1 : l0), 32'(vt[i].lat));
            chk($sformatf("v%0d out", i), 32'(vt[i].core ? o1 : o0), 32'(vt[i].out));
            chk($sformatf("v%0d err", i), 32'(vt[i].core ? e1 : e0), 32'(vt[i].err));
        end

        do_reset();
        pair(1, 1, WR, WR, 16'h8030, 16'h8031, 16'h0AAA, 16'h0BBB, l0, l1, o0, o1, e0, e1);
        chk("contend1 lat0", 32'(l0), 32'd2);
        chk("contend1 lat1", 32'(l1), 32'd3);
        pair(1, 0, RD, RD, 16'h8031, 16'h0000, 16'h0, 16'h0, l0, l1, o0, o1, e0, e1);
        chk("solo lat0", 32'(l0), 32'd2);
        chk("solo out0", 32'(o0), 32'h0BBB);
        pair(1, 1, RD, RD, 16'h8030, 16'h8031, 16'h0, 16'h0, l0, l1, o0, o1, e0, e1);
        chk("contend2 lat1", 32'(l1), 32'd2);
        chk("contend2 lat0", 32'(l0), 32'd3);
        chk("contend2 out0", 32'(o0), 32'h0AAA);
        chk("contend2 out1", 32'(o1), 32'h0BBB);

        do_reset();
        pair(1, 1, WR, RD, 16'h8001, 16'h8001, 16'h5555, 16'h0, l0, l1, o0, o1, e0, e1);
        chk("order lat0", 32'(l0), 32'd2);
        chk("order lat1", 32'(l1), 32'd3);
        chk("order out1", 32'(o1), 32'h5555);

        @(negedge clk);
        drive(0, WR, 16'h0010, 16'h0001);
        drive(1, RD, 16'h8001, 16'h0000);
        @(posedge clk);
        #2;
        bus.dataREQ = '0;
        rst = 1'b1;
        #1;
        chk("midrst ack", 32'(bus.dataACK), 32'd0);
        chk("midrst err", 32'(bus.dataERR), 32'd0);
        chk("midrst out", 32'(bus.dataOUT), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        acks = '0;
        repeat (4) begin @(negedge clk); acks |= bus.dataACK; end
        chk("postrst no ack", 32'(acks), 32'd0);
        pair(1, 1, RD, RD, 16'h8001, 16'h8030, 16'h0, 16'h0, l0, l1, o0, o1, e0, e1);
        chk("postrst lat0", 32'(l0), 32'd2);
        chk("postrst lat1", 32'(l1), 32'd3);
        chk("postrst out0", 32'(o0), 32'h5555);
        chk("postrst out1", 32'(o1), 32'h0AAA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
